// File: rtl/sam_pkg.sv
// sam_pkg: opcodes, FSM states and ALU selects shared by the accumulator core.
// Latency: none (declarations and pure decode helpers only).
// Backpressure: not applicable; timing is owned by sam_core_p.
// Ports: none.
package sam_pkg;

   // Opcode values carried in the top bits of IR.
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_JMP   = 3'b100;
   localparam logic [2:0] OP_JNEG  = 3'b101;
   localparam logic [2:0] OP_JZERO = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      MEM_RD,
      MEM_WR,
      HALTED
   } state_t;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_ADD  = 2'd1,
      ALU_SUB  = 2'd2
   } alu_op_t;

   // Opcodes that need a data read before they can retire.
   function automatic logic op_reads_mem(input logic [2:0] op);
      return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // ALU select for the read-class opcodes; LOAD passes the read data through.
   function automatic alu_op_t op_to_alu(input logic [2:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         default: return ALU_PASS;
      endcase
   endfunction

   // Branch decision for the control-flow opcodes; anything else never branches.
   function automatic logic branch_taken(input logic [2:0] op,
                                         input logic       ac_neg,
                                         input logic       ac_zero);
      case (op)
         OP_JMP:   return 1'b1;
         OP_JNEG:  return ac_neg;
         OP_JZERO: return ac_zero;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sam_alu.sv
// sam_alu: DATA_W+1-bit add / subtract / pass-B for the accumulator, carry out on top bit.
// Latency: combinational.
// Backpressure: none; result is qualified by the core's memory completion.
// Ports: i_op select, i_a (AC), i_b (read data) -> o_res, o_carry (carry on ADD, borrow on SUB).
module sam_alu
   import sam_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  alu_op_t           i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_res,
   output logic              o_carry
);

   logic [DATA_W:0] w_sum;

   // Zero-extending both operands makes bit DATA_W the carry for ADD and
   // the borrow for SUB (it goes high exactly when i_b > i_a).
   always_comb begin
      w_sum = {1'b0, i_b};
      case (i_op)
         ALU_ADD: w_sum = {1'b0, i_a} + {1'b0, i_b};
         ALU_SUB: w_sum = {1'b0, i_a} - {1'b0, i_b};
         default: w_sum = {1'b0, i_b};
      endcase
   end

   assign o_res   = w_sum[DATA_W-1:0];
   assign o_carry = w_sum[DATA_W];

endmodule

// File: rtl/sam_core_p.sv
// sam_core_p: FSM-sequenced accumulator core; fetch/decode/execute on AC over a req/wait memory port.
// Latency: JMP/JNEG/JZERO/HALT 2 cycles, LOAD/STORE/ADD/SUB 3 cycles, +1 per mem_wait cycle.
// Backpressure: mem_wait stalls with req/we/addr/wdata held; run=0 only blocks issuing a new fetch.
// Ports: clk, reset (sync, active-high); run fetch gate; mem_req/mem_we/mem_addr/mem_wdata out,
//        mem_rdata/mem_wait in (completion = mem_req & ~mem_wait); halted, pc, ac, carry status.
module sam_core_p
   import sam_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int OPC_W    = 3,
   parameter int ADDR_W   = DATA_W - OPC_W,
   parameter int PC_STEP  = 2,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_wait,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ac,
   output logic              carry
);

   state_t            r_state,     w_state_nxt;
   logic [ADDR_W-1:0] r_pc,        w_pc_nxt;
   logic [DATA_W-1:0] r_ac,        w_ac_nxt;
   logic [DATA_W-1:0] r_ir,        w_ir_nxt;
   logic              r_carry,     w_carry_nxt;
   logic              r_halted,    w_halted_nxt;
   logic              r_mem_req,   w_req_nxt;
   logic              r_mem_we,    w_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr,  w_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;

   logic [OPC_W-1:0]  w_opc;
   logic [ADDR_W-1:0] w_operand;
   logic [ADDR_W-1:0] w_target;
   logic              w_done;
   alu_op_t           w_alu_op;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_carry;

   assign w_opc     = r_ir[DATA_W-1 -: OPC_W];
   assign w_operand = r_ir[ADDR_W-1:0];
   assign w_done    = r_mem_req & ~mem_wait;
   assign w_alu_op  = op_to_alu(w_opc);

   // r_pc already holds the post-fetch increment (including any wrap), so a
   // taken branch simply replaces it.
   assign w_target  = branch_taken(w_opc, r_ac[DATA_W-1], (r_ac == '0)) ? w_operand : r_pc;

   sam_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_op    (w_alu_op),
      .i_a     (r_ac),
      .i_b     (mem_rdata),
      .o_res   (w_alu_res),
      .o_carry (w_alu_carry)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_ac_nxt     = r_ac;
      w_ir_nxt     = r_ir;
      w_carry_nxt  = r_carry;
      w_halted_nxt = r_halted;
      w_req_nxt    = r_mem_req;
      w_we_nxt     = r_mem_we;
      w_addr_nxt   = r_mem_addr;
      w_wdata_nxt  = r_mem_wdata;

      case (r_state)
         FETCH: begin
            if (r_mem_req) begin
               // Fetch in flight: finishes regardless of run.
               if (w_done) begin
                  w_ir_nxt    = mem_rdata;
                  w_pc_nxt    = r_pc + ADDR_W'(PC_STEP);
                  w_req_nxt   = 1'b0;
                  w_state_nxt = DECODE;
               end
            end else if (run) begin
               w_req_nxt  = 1'b1;
               w_we_nxt   = 1'b0;
               w_addr_nxt = r_pc;
            end
         end

         DECODE: begin
            if (op_reads_mem(w_opc)) begin
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b0;
               w_addr_nxt  = w_operand;
               w_state_nxt = MEM_RD;
            end else if (w_opc == OP_STORE) begin
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b1;
               w_addr_nxt  = w_operand;
               w_wdata_nxt = r_ac;
               w_state_nxt = MEM_WR;
            end else if (w_opc == OP_HALT) begin
               w_halted_nxt = 1'b1;
               w_state_nxt  = HALTED;
            end else begin
               // Control flow: issue the next fetch straight from here so the
               // instruction retires in two cycles.
               w_pc_nxt    = w_target;
               w_req_nxt   = run;
               w_we_nxt    = 1'b0;
               w_addr_nxt  = w_target;
               w_state_nxt = FETCH;
            end
         end

         MEM_RD: begin
            if (w_done) begin
               w_ac_nxt = w_alu_res;
               // LOAD leaves the carry from the last ADD/SUB untouched.
               if (w_alu_op != ALU_PASS) begin
                  w_carry_nxt = w_alu_carry;
               end
               w_req_nxt   = run;
               w_we_nxt    = 1'b0;
               w_addr_nxt  = r_pc;
               w_state_nxt = FETCH;
            end
         end

         MEM_WR: begin
            if (w_done) begin
               w_req_nxt   = run;
               w_we_nxt    = 1'b0;
               w_addr_nxt  = r_pc;
               w_state_nxt = FETCH;
            end
         end

         HALTED: begin
            w_req_nxt = 1'b0;
         end

         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= FETCH;
         r_pc        <= ADDR_W'(RESET_PC);
         r_ac        <= '0;
         r_ir        <= '0;
         r_carry     <= 1'b0;
         r_halted    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_ac        <= w_ac_nxt;
         r_ir        <= w_ir_nxt;
         r_carry     <= w_carry_nxt;
         r_halted    <= w_halted_nxt;
         r_mem_req   <= w_req_nxt;
         r_mem_we    <= w_we_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_mem_wdata <= w_wdata_nxt;
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign halted    = r_halted;
   assign pc        = r_pc;
   assign ac        = r_ac;
   assign carry     = r_carry;

endmodule

// File: doc/sam_core_p.md
Name: sam_core_p

Overview:
- Parametrised, synthesisable successor to the accumulator machine datapath/controller pair.
- Single FSM-sequenced accumulator core: fetches instructions over a request/wait memory handshake, decodes a 3-bit opcode, executes on AC.
- Adds SUB, zero-branch, HALT, run gating and a carry flag; sits between the testbench/top and the shared word memory model.

Parameters:
- DATA_W, 16, word width of AC, IR, memory data.
- OPC_W, 3, opcode field width in IR[DATA_W-1 -: OPC_W].
- ADDR_W, DATA_W-OPC_W, address/PC width; operand address = IR[ADDR_W-1:0].
- PC_STEP, 2, PC increment per fetch.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  when low, core does not issue a new fetch.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  write data (AC).
- mem_rdata  in  DATA_W  read data, valid in the completion cycle.
- mem_wait  in  1  memory busy; completion = mem_req & ~mem_wait.
- halted  out  1  core executed HALT.
- pc  out  ADDR_W  debug PC.
- ac  out  DATA_W  debug accumulator.
- carry  out  1  carry/borrow from last ADD/SUB.

Behaviour:
- Reset (reset=1 at an edge): PC=RESET_PC, AC=0, IR=0, carry=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=FETCH. Applies mid-transaction: mem_req drops at that edge; the memory model must accept an abandoned request.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 JMP, 101 JNEG, 110 JZERO, 111 HALT.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the completion cycle. mem_req may stay high back-to-back into the next transaction. Wait states are unbounded.
- FETCH: if run=1, drive req=1, we=0, addr=PC. On completion: IR<=mem_rdata, PC<=PC+PC_STEP (mod 2^ADDR_W), go to DECODE. If run=0, req=0 and the core stays in FETCH.
- DECODE, one cycle, no memory access except as listed:
  - LOAD/ADD/SUB: go to MEM_RD, addr=IR operand.
  - STORE: go to MEM_WR, addr=operand, wdata=AC, we=1.
  - JMP: PC<=operand, go to FETCH.
  - JNEG: if AC[DATA_W-1]=1 then PC<=operand; go to FETCH.
  - JZERO: if AC==0 then PC<=operand; go to FETCH.
  - HALT: halted<=1, go to HALTED.
- MEM_RD completion:
  - LOAD: AC<=rdata.
  - ADD: {carry,AC}<=AC+rdata.
  - SUB: {carry,AC}<=AC-rdata, carry=1 on borrow.
  - Arithmetic is mod 2^DATA_W. Go to FETCH.
- MEM_WR completion: go to FETCH; AC unchanged.
- HALTED: no requests; only reset exits; halted stays 1.
- Latency with zero wait states: JMP/JNEG/JZERO/HALT take 2 cycles; LOAD/STORE/ADD/SUB take 3 cycles. Each wait cycle adds 1.
- run only gates the FETCH issue. An in-flight fetch, or an instruction already in progress, completes regardless of run.
- Branch taken at the same PC+PC_STEP wrap: the branch target wins.

Decomposition:
- Package sam_pkg: opcode localparams, FSM state enum {FETCH, DECODE, MEM_RD, MEM_WR, HALTED}, operand/opcode field helper functions.
- Sub-module sam_alu: combinational DATA_W+1-bit add/sub/pass-B with carry out.
- FSM, registers and handshake stay in sam_core_p.

Test Plan:
- Reset, run=1, mem[0]=LOAD 0x10, mem[0x10]=0x0005, zero wait -> mem_req at cycle 1; AC=0x0005 after 3 cycles; PC=2.
- LOAD 0xFFFF then ADD of 0x0001 -> AC=0x0000, carry=1; JZERO 0x40 -> next fetch addr=0x40.
- LOAD 0x0003, SUB 0x0005 -> AC=0xFFFE, carry=1; JNEG 0x20 taken; JNEG with AC=0x0001 not taken (fetch PC+2).
- STORE with mem_wait held high 4 cycles -> mem_req/we/addr/wdata stable for 5 cycles, then the next fetch issues.
- HALT at 0x06 -> halted=1, mem_req stays 0 for 20 cycles; reset -> halted=0, fetch at RESET_PC.
- reset asserted during a wait-stalled fetch -> mem_req=0 the next cycle, AC=0; run=0 holds the core idle with no requests until run=1.
